lru2_refill_ctrl: RTL

Miss/refill sequencer for a 2-way set-associative cache that owns the single index port of the per-set 2-way LRU bit array. It selects a victim way on a miss, preferring an invalid way and otherwise the LRU way. It then sequences an optional dirty writeback and the line refill, and finally marks the filled way most-recently-used. It also arbitrates hit-driven LRU updates from the lookup pipeline onto the same LRU port.

---
 rtl/lru2_refill_ctrl_if.sv | 50 +++++
 rtl/lru2_refill_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lru2_refill_ctrl_if.sv
// Miss/hit/LRU/writeback/refill signal bundle between the lookup side and the
// 2-way refill controller.
interface lru2_refill_ctrl_if #(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned CNT_BITS   = 16
);
    logic                  miss_valid;
    logic                  miss_ready;
    logic [INDEX_BITS-1:0] miss_index;
    logic [1:0]            miss_way_valid;
    logic [1:0]            miss_way_dirty;
    logic                  hit_valid;
    logic                  hit_ready;
    logic [INDEX_BITS-1:0] hit_index;
    logic                  hit_way;
    logic [INDEX_BITS-1:0] lru_index;
    logic                  lru_way;
    logic                  lru_update;
    logic                  lru_ref;
    logic                  wb_req_valid;
    logic                  wb_req_ready;
    logic                  wb_way;
    logic                  refill_req_valid;
    logic                  refill_req_ready;
    logic                  refill_done;
    logic                  fill_way;
    logic                  done_valid;
    logic [CNT_BITS-1:0]   refill_cnt;
    logic [CNT_BITS-1:0]   wb_cnt;

    // Environment side: lookup pipeline, LRU array and memory interface.
    modport master (
        output miss_valid, miss_index, miss_way_valid, miss_way_dirty,
        output hit_valid, hit_index, hit_way,
        output lru_way, wb_req_ready, refill_req_ready, refill_done,
        input  miss_ready, hit_ready, lru_index, lru_update, lru_ref,
        input  wb_req_valid, wb_way, refill_req_valid, fill_way, done_valid,
        input  refill_cnt, wb_cnt
    );

    // Controller side.
    modport slave (
        input  miss_valid, miss_index, miss_way_valid, miss_way_dirty,
        input  hit_valid, hit_index, hit_way,
        input  lru_way, wb_req_ready, refill_req_ready, refill_done,
        output miss_ready, hit_ready, lru_index, lru_update, lru_ref,
        output wb_req_valid, wb_way, refill_req_valid, fill_way, done_valid,
        output refill_cnt, wb_cnt
    );
endinterface

// File: rtl/lru2_refill_ctrl.sv
// Miss/refill sequencer for a 2-way cache: victim selection, writeback, refill,
// MRU marking, and arbitration of hit-driven LRU updates onto the one LRU port.
module lru2_refill_ctrl #(
    parameter int unsigned ENTRIES    = 256,
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    lru2_refill_ctrl_if.slave bus
);
    localparam int unsigned SETS = 1 << INDEX_BITS;

    if (SETS != ENTRIES) begin : g_bad_cfg
        $error("lru2_refill_ctrl: ENTRIES must equal 2**INDEX_BITS");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        WB      = 3'd2,
        RF_REQ  = 3'd3,
        RF_WAIT = 3'd4,
        UPDATE  = 3'd5
    } state_t;

    state_t                state;
    logic [INDEX_BITS-1:0] idx_q;
    logic [1:0]            valid_q;
    logic [1:0]            dirty_q;
    logic                  miss_ready_q;
    logic                  hit_ready_q;
    logic                  wb_req_q;
    logic                  rf_req_q;
    logic                  done_q;
    logic                  fill_way_q;
    logic                  wb_way_q;
    logic [CNT_BITS-1:0]   refill_cnt_q;
    logic [CNT_BITS-1:0]   wb_cnt_q;

    logic                  victim_c;
    logic                  hit_take_c;
    logic [INDEX_BITS-1:0] lru_index_c;
    logic                  lru_update_c;
    logic                  lru_ref_c;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (&c) ? c : c + CNT_BITS'(1);
    endfunction

    // Invalid way wins over LRU; way 0 first.
    assign victim_c = !valid_q[0] ? 1'b0 : (!valid_q[1] ? 1'b1 : bus.lru_way);

    // State register with registered handshake, pulse and counter outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx_q        <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_ready_q <= 1'b1;
            hit_ready_q  <= 1'b1;
            wb_req_q     <= 1'b0;
            rf_req_q     <= 1'b0;
            done_q       <= 1'b0;
            fill_way_q   <= 1'b0;
            wb_way_q     <= 1'b0;
            refill_cnt_q <= '0;
            wb_cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.miss_valid) begin
                        idx_q        <= bus.miss_index;
                        valid_q      <= bus.miss_way_valid;
                        dirty_q      <= bus.miss_way_dirty;
                        miss_ready_q <= 1'b0;
                        hit_ready_q  <= 1'b0;
                        state        <= SELECT;
                    end
                end
                SELECT: begin
                    fill_way_q  <= victim_c;
                    wb_way_q    <= victim_c;
                    hit_ready_q <= 1'b1;
                    if (valid_q[victim_c] && dirty_q[victim_c]) begin
                        wb_req_q <= 1'b1;
                        state    <= WB;
                    end else begin
                        rf_req_q <= 1'b1;
                        state    <= RF_REQ;
                    end
                end
                WB: begin
                    if (bus.wb_req_ready) begin
                        wb_req_q <= 1'b0;
                        rf_req_q <= 1'b1;
                        wb_cnt_q <= sat_inc(wb_cnt_q);
                        state    <= RF_REQ;
                    end
                end
                RF_REQ: begin
                    if (bus.refill_req_ready) begin
                        rf_req_q <= 1'b0;
                        state    <= RF_WAIT;
                    end
                end
                RF_WAIT: begin
                    if (bus.refill_done) begin
                        hit_ready_q  <= 1'b0;
                        done_q       <= 1'b1;
                        refill_cnt_q <= sat_inc(refill_cnt_q);
                        state        <= UPDATE;
                    end
                end
                UPDATE: begin
                    miss_ready_q <= 1'b1;
                    hit_ready_q  <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // LRU port mux: the final MRU write owns the port, otherwise an accepted hit.
    always_comb begin
        hit_take_c   = bus.hit_valid && hit_ready_q;
        lru_index_c  = idx_q;
        lru_update_c = 1'b0;
        lru_ref_c    = 1'b0;
        if (state == UPDATE) begin
            lru_update_c = 1'b1;
            lru_ref_c    = fill_way_q;
        end else if (hit_take_c) begin
            lru_index_c  = bus.hit_index;
            lru_update_c = 1'b1;
            lru_ref_c    = bus.hit_way;
        end
    end

    assign bus.miss_ready       = miss_ready_q;
    assign bus.hit_ready        = hit_ready_q;
    assign bus.lru_index        = lru_index_c;
    assign bus.lru_update       = lru_update_c;
    assign bus.lru_ref          = lru_ref_c;
    assign bus.wb_req_valid     = wb_req_q;
    assign bus.wb_way           = wb_way_q;
    assign bus.refill_req_valid = rf_req_q;
    assign bus.fill_way         = fill_way_q;
    assign bus.done_valid       = done_q;
    assign bus.refill_cnt       = refill_cnt_q;
    assign bus.wb_cnt           = wb_cnt_q;
endmodule
